// File: rtl/ula_seq_pkg.sv
// Shared types, common function selects and the propagate/generate merge for the
// byte-serial ALU sequencer.
package ula_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Common 74181 selects (arithmetic add/sub with M=0, XOR with M=1)
   localparam logic [3:0] S_ADD = 4'b1001;
   localparam logic [3:0] S_SUB = 4'b0110;
   localparam logic [3:0] S_XOR = 4'b0110;

   // Group generate of a higher chunk stacked on top of an already merged lower chunk
   function automatic logic pg_merge_g(input logic g_hi, input logic p_hi, input logic g_lo);
      return g_hi | (p_hi & g_lo);
   endfunction

endpackage

// File: rtl/ula_8_bits.sv
// 8-bit 74181-style ALU slice with active-high data and active-high carry-in.
// Arithmetic result is t1 + t2 + c_in, logic result is ~(t1 ^ t2).
module ula_8_bits (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic [3:0] s_i,
   input  logic       m_i,
   input  logic       c_in_i,
   output logic [7:0] f_o,
   output logic       c_out_o,
   output logic       overflow_o,
   output logic       a_eq_b_o,
   output logic       p_o,
   output logic       g_o
);

   logic [7:0] t1;
   logic [7:0] t2;
   logic [8:0] sum;
   logic [7:0] f;

   // Per-bit 74181 terms, ripple sum and group flags
   always_comb begin
      t1  = a_i | (b_i & {8{s_i[0]}}) | (~b_i & {8{s_i[1]}});
      t2  = (a_i & ~b_i & {8{s_i[2]}}) | (a_i & b_i & {8{s_i[3]}});
      sum = {1'b0, t1} + {1'b0, t2} + {8'd0, c_in_i};
      f   = m_i ? ~(t1 ^ t2) : sum[7:0];
      f_o = f;
      // Carry chains in both modes; only the arithmetic mode reports overflow
      c_out_o    = sum[8];
      overflow_o = m_i ? 1'b0 : (~(t1[7] ^ t2[7]) & (sum[7] ^ t1[7]));
      a_eq_b_o   = &f;
      // t2 is always a subset of t1, so t1 alone is the per-bit propagate
      p_o        = &t1;
      g_o        = (({1'b0, t1} + {1'b0, t2}) > 9'd255);
   end

endmodule

// File: rtl/ula_seq_multibyte.sv
// Byte-serial wide ALU: one ula_8_bits slice is reused N_BYTES times, LSB first,
// with the carry registered between passes and the group flags accumulated.
module ula_seq_multibyte
   import ula_seq_pkg::*;
#(
   parameter int unsigned N_BYTES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [8*N_BYTES-1:0] req_a,
   input  logic [8*N_BYTES-1:0] req_b,
   input  logic [3:0]           req_s,
   input  logic                 req_m,
   input  logic                 req_c_in,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [8*N_BYTES-1:0] rsp_f,
   output logic                 rsp_c_out,
   output logic                 rsp_overflow,
   output logic                 rsp_a_eq_b,
   output logic                 rsp_p,
   output logic                 rsp_g
);

   localparam int unsigned    IdxW    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BYTES - 1);

   state_e                    state_q, state_d;
   logic [IdxW-1:0]           idx_q, idx_d;
   logic [N_BYTES-1:0][7:0]   a_q, a_d;
   logic [N_BYTES-1:0][7:0]   b_q, b_d;
   logic [3:0]                s_q, s_d;
   logic                      m_q, m_d;
   logic                      carry_q, carry_d;
   logic                      p_acc_q, p_acc_d;
   logic                      g_acc_q, g_acc_d;
   logic                      eq_acc_q, eq_acc_d;
   logic [N_BYTES-1:0][7:0]   f_q, f_d;
   logic                      c_out_q, c_out_d;
   logic                      ovf_q, ovf_d;
   logic                      eq_q, eq_d;
   logic                      p_q, p_d;
   logic                      g_q, g_d;

   logic [7:0] slice_f;
   logic       slice_c_out, slice_ovf, slice_eq, slice_p, slice_g;

   ula_8_bits u_slice (
      .a_i        (a_q[idx_q]),
      .b_i        (b_q[idx_q]),
      .s_i        (s_q),
      .m_i        (m_q),
      .c_in_i     (carry_q),
      .f_o        (slice_f),
      .c_out_o    (slice_c_out),
      .overflow_o (slice_ovf),
      .a_eq_b_o   (slice_eq),
      .p_o        (slice_p),
      .g_o        (slice_g)
   );

   // Handshake outputs and result word straight from registers
   always_comb begin
      req_ready    = (state_q == StIdle) && !rst;
      rsp_valid    = (state_q == StDone);
      rsp_f        = f_q;
      rsp_c_out    = c_out_q;
      rsp_overflow = ovf_q;
      rsp_a_eq_b   = eq_q;
      rsp_p        = p_q;
      rsp_g        = g_q;
   end

   // Next-state: capture in IDLE, one byte pass per cycle in RUN, hold in DONE
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      m_d      = m_q;
      carry_d  = carry_q;
      p_acc_d  = p_acc_q;
      g_acc_d  = g_acc_q;
      eq_acc_d = eq_acc_q;
      f_d      = f_q;
      c_out_d  = c_out_q;
      ovf_d    = ovf_q;
      eq_d     = eq_q;
      p_d      = p_q;
      g_d      = g_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               a_d      = req_a;
               b_d      = req_b;
               s_d      = req_s;
               m_d      = req_m;
               carry_d  = req_c_in;
               p_acc_d  = 1'b1;
               g_acc_d  = 1'b0;
               eq_acc_d = 1'b1;
               idx_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            f_d[idx_q] = slice_f;
            carry_d    = slice_c_out;
            eq_acc_d   = eq_acc_q & slice_eq;
            p_acc_d    = p_acc_q & slice_p;
            g_acc_d    = pg_merge_g(slice_g, slice_p, g_acc_q);
            if (idx_q == LastIdx) begin
               c_out_d = slice_c_out;
               ovf_d   = slice_ovf;
               eq_d    = eq_acc_d;
               p_d     = p_acc_d;
               g_d     = g_acc_d;
               state_d = StDone;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StDone: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; synchronous reset discards any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         m_q      <= 1'b0;
         carry_q  <= 1'b0;
         p_acc_q  <= 1'b0;
         g_acc_q  <= 1'b0;
         eq_acc_q <= 1'b0;
         f_q      <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         eq_q     <= 1'b0;
         p_q      <= 1'b0;
         g_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         m_q      <= m_d;
         carry_q  <= carry_d;
         p_acc_q  <= p_acc_d;
         g_acc_q  <= g_acc_d;
         eq_acc_q <= eq_acc_d;
         f_q      <= f_d;
         c_out_q  <= c_out_d;
         ovf_q    <= ovf_d;
         eq_q     <= eq_d;
         p_q      <= p_d;
         g_q      <= g_d;
      end
   end

endmodule

// File: tb/tb_ula_seq_multibyte.sv
// Bench for ula_seq_multibyte: three instances (1, 2 and 4 bytes) share one request
// bus; hand-computed 16-bit vectors plus a full select sweep against a word-level model.
module tb_ula_seq_multibyte;
   import ula_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_a, req_b;
   logic [3:0]  req_s;
   logic        req_m, req_c_in;
   logic        rsp_ready;

   logic        rr1, rr2, rr4, v1, v2, v4;
   logic [7:0]  f1;
   logic [15:0] f2;
   logic [31:0] f4;
   logic        c1, c2, c4, o1, o2, o4, e1, e2, e4, p1, p2, p4, g1, g2, g4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ula_seq_multibyte #(.N_BYTES(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1),
      .req_a(req_a[7:0]), .req_b(req_b[7:0]), .req_s(req_s), .req_m(req_m),
      .req_c_in(req_c_in), .rsp_valid(v1), .rsp_ready(rsp_ready), .rsp_f(f1),
      .rsp_c_out(c1), .rsp_overflow(o1), .rsp_a_eq_b(e1), .rsp_p(p1), .rsp_g(g1)
   );

   ula_seq_multibyte #(.N_BYTES(2)) dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr2),
      .req_a(req_a[15:0]), .req_b(req_b[15:0]), .req_s(req_s), .req_m(req_m),
      .req_c_in(req_c_in), .rsp_valid(v2), .rsp_ready(rsp_ready), .rsp_f(f2),
      .rsp_c_out(c2), .rsp_overflow(o2), .rsp_a_eq_b(e2), .rsp_p(p2), .rsp_g(g2)
   );

   ula_seq_multibyte #(.N_BYTES(4)) dut4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr4),
      .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m),
      .req_c_in(req_c_in), .rsp_valid(v4), .rsp_ready(rsp_ready), .rsp_f(f4),
      .rsp_c_out(c4), .rsp_overflow(o4), .rsp_a_eq_b(e4), .rsp_p(p4), .rsp_g(g4)
   );

   typedef struct packed {
      logic [31:0] f;
      logic        c;
      logic        ovf;
      logic        eq;
      logic        p;
      logic        g;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  s;
      logic        m;
      logic        cin;
      logic [15:0] f;
      logic        c;
      logic        ovf;
      logic        eq;
      logic        p;
      logic        g;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Word-level reference from the 74181 function table: arithmetic is X + Y + cin
   function automatic res_t model(input logic [31:0] a_in, input logic [31:0] b_in,
                                  input logic [3:0] s, input logic m, input logic cin,
                                  input int w);
      logic [31:0] mask, a, b, nb, lf, xs, ys;
      logic [32:0] sum, gsum, lsum;
      res_t        r;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      a  = a_in & mask;
      b  = b_in & mask;
      nb = ~b_in & mask;
      case (s)
         4'h0: begin xs = a;      ys = '0;     lf = ~a;      end
         4'h1: begin xs = a | b;  ys = '0;     lf = ~(a | b); end
         4'h2: begin xs = a | nb; ys = '0;     lf = ~a & b;  end
         4'h3: begin xs = mask;   ys = '0;     lf = '0;      end
         4'h4: begin xs = a;      ys = a & nb; lf = ~(a & b); end
         4'h5: begin xs = a | b;  ys = a & nb; lf = ~b;      end
         4'h6: begin xs = a;      ys = nb;     lf = a ^ b;   end
         4'h7: begin xs = a & nb; ys = mask;   lf = a & nb;  end
         4'h8: begin xs = a;      ys = a & b;  lf = ~a | b;  end
         4'h9: begin xs = a;      ys = b;      lf = ~(a ^ b); end
         4'hA: begin xs = a | nb; ys = a & b;  lf = b;       end
         4'hB: begin xs = a & b;  ys = mask;   lf = a & b;   end
         4'hC: begin xs = a;      ys = a;      lf = '1;      end
         4'hD: begin xs = a | b;  ys = a;      lf = a | nb;  end
         4'hE: begin xs = a | nb; ys = a;      lf = a | b;   end
         default: begin xs = a;   ys = mask;   lf = a;       end
      endcase
      sum   = {1'b0, xs} + {1'b0, ys} + {32'd0, cin};
      gsum  = {1'b0, xs} + {1'b0, ys};
      lsum  = {1'b0, xs & (mask >> 1)} + {1'b0, ys & (mask >> 1)} + {32'd0, cin};
      r.c   = sum[w];
      r.g   = gsum[w];
      r.f   = (m ? lf : sum[31:0]) & mask;
      r.ovf = m ? 1'b0 : (lsum[w-1] ^ sum[w]);
      r.eq  = &(r.f | ~mask);
      r.p   = &(xs | ys | ~mask);
      return r;
   endfunction

   task automatic chk_res(input string tag, input res_t e, input logic [31:0] f,
                          input logic c, input logic ovf, input logic eq,
                          input logic p, input logic g);
      chk({tag, " f"}, f, e.f);
      chk({tag, " c_out"}, {31'd0, c}, {31'd0, e.c});
      chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
      chk({tag, " a_eq_b"}, {31'd0, eq}, {31'd0, e.eq});
      chk({tag, " p"}, {31'd0, p}, {31'd0, e.p});
      chk({tag, " g"}, {31'd0, g}, {31'd0, e.g});
   endtask

   // One operation on all three instances: latency and every field against the model
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                         input logic m, input logic cin,
                         output logic [15:0] f2o, output logic [4:0] fl2o);
      int    lat1, lat2, lat4;
      string tag;
      lat1 = -1;
      lat2 = -1;
      lat4 = -1;
      tag  = $sformatf("m=%0d s=%h cin=%0d a=%h b=%h", m, s, cin, a, b);
      req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = cin; req_valid = 1'b1;
      chk({tag, " req_ready"}, {29'd0, rr1, rr2, rr4}, 32'd7);
      @(posedge clk); #1;
      // Request inputs are don't-care once accepted
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_s = 4'($urandom); req_m = 1'($urandom);
      req_c_in = 1'($urandom);
      chk({tag, " early_valid"}, {29'd0, v1, v2, v4}, 32'd0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (v1 && lat1 < 0) lat1 = k;
         if (v2 && lat2 < 0) lat2 = k;
         if (v4 && lat4 < 0) lat4 = k;
      end
      chk({tag, " lat1"}, lat1, 32'd1);
      chk({tag, " lat2"}, lat2, 32'd2);
      chk({tag, " lat4"}, lat4, 32'd4);
      chk_res({tag, " n1"}, model(a, b, s, m, cin, 8), {24'd0, f1}, c1, o1, e1, p1, g1);
      chk_res({tag, " n2"}, model(a, b, s, m, cin, 16), {16'd0, f2}, c2, o2, e2, p2, g2);
      chk_res({tag, " n4"}, model(a, b, s, m, cin, 32), f4, c4, o4, e4, p4, g4);
      f2o  = f2;
      fl2o = {c2, o2, e2, p2, g2};
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   vec_t        tbl[11];
   logic [15:0] got_f;
   logic [4:0]  got_fl;
   logic [31:0] ra, rb;
   int          seen;

   initial begin
      // a, b, s, m, cin -> f, c_out, ovf, a_eq_b, p, g  (16-bit, hand-computed)
      tbl[0]  = '{16'h00FF, 16'h0001, S_ADD,   1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{16'h7FFF, 16'h0001, S_ADD,   1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{16'hAAAA, 16'h5555, S_XOR,   1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{16'h0005, 16'h0003, S_SUB,   1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{16'hFFFF, 16'h0001, S_ADD,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{16'h8000, 16'h0001, S_SUB,   1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{16'hF0F0, 16'hFF00, 4'b1011, 1'b1, 1'b0, 16'hF000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7]  = '{16'h1234, 16'h5678, 4'b1100, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{16'h1234, 16'h4321, S_ADD,   1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{16'hFF00, 16'h00FF, S_ADD,   1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{16'hFF00, 16'h00FF, S_ADD,   1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_s = '0; req_m = 1'b0;
      req_c_in = 1'b0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset valid", {29'd0, v1, v2, v4}, 32'd0);
      chk("reset ready_in_rst", {29'd0, rr1, rr2, rr4}, 32'd0);
      chk("reset f2", {16'd0, f2}, 32'd0);
      chk("reset flags2", {27'd0, c2, o2, e2, p2, g2}, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready after reset", {29'd0, rr1, rr2, rr4}, 32'd7);

      // Directed 16-bit vectors
      for (int i = 0; i < 11; i++) begin
         run_op({16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].s, tbl[i].m, tbl[i].cin,
                got_f, got_fl);
         chk($sformatf("vec%0d f", i), {16'd0, got_f}, {16'd0, tbl[i].f});
         chk($sformatf("vec%0d flags{c,ovf,eq,p,g}", i), {27'd0, got_fl},
             {27'd0, tbl[i].c, tbl[i].ovf, tbl[i].eq, tbl[i].p, tbl[i].g});
      end

      // Backpressure: response held while rsp_ready=0, new request ignored
      req_a = 32'h1; req_b = 32'h2; req_s = S_ADD; req_m = 1'b0; req_c_in = 1'b0;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_a = 32'h10; req_b = 32'h20;
      for (int k = 0; k < 8 && !(v1 && v2 && v4); k++) begin
         @(posedge clk); #1;
      end
      chk("bp all valid", {29'd0, v1, v2, v4}, 32'd7);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp hold%0d f2", k), {16'd0, f2}, 32'h3);
         chk($sformatf("bp hold%0d valid/ready", k), {30'd0, v2, rr2}, 32'd2);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp release valid/ready", {30'd0, v2, rr2}, 32'd1);
      chk("bp idle keeps f2", {16'd0, f2}, 32'h3);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("bp next accepted", {31'd0, rr2}, 32'd0);
      for (int k = 0; k < 8 && !(v1 && v2 && v4); k++) begin
         @(posedge clk); #1;
      end
      chk("bp next valid", {29'd0, v1, v2, v4}, 32'd7);
      chk("bp next f2", {16'd0, f2}, 32'h30);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset right after acceptance (idx 0 of RUN): no response, registers cleared
      req_a = 32'h1234; req_b = 32'h1111; req_s = S_ADD; req_m = 1'b0; req_c_in = 1'b1;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst mid ready low", {29'd0, rr1, rr2, rr4}, 32'd0);
      @(posedge clk); #1;
      chk("rst mid valid", {29'd0, v1, v2, v4}, 32'd0);
      chk("rst mid f2", {16'd0, f2}, 32'd0);
      chk("rst mid flags2", {27'd0, c2, o2, e2, p2, g2}, 32'd0);
      chk("rst mid ready in rst", {31'd0, rr2}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst mid ready after", {29'd0, rr1, rr2, rr4}, 32'd7);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (v1 || v2 || v4) seen++;
      end
      chk("rst mid no response", seen, 32'd0);

      // Sweep all {M,S} x c_in x operand patterns on 1, 2 and 4 bytes
      for (int mi = 0; mi < 2; mi++) begin
         for (int si = 0; si < 16; si++) begin
            for (int ci = 0; ci < 2; ci++) begin
               for (int op = 0; op < 5; op++) begin
                  case (op)
                     0: begin ra = 32'h0000_0000; rb = 32'h0000_0000; end
                     1: begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
                     2: begin ra = 32'hAAAA_AAAA; rb = 32'h5555_5555; end
                     3: begin ra = 32'h0F0F_0F0F; rb = 32'hF0F0_F0F0; end
                     default: begin ra = $urandom; rb = $urandom; end
                  endcase
                  run_op(ra, rb, 4'(si), 1'(mi), 1'(ci), got_f, got_fl);
               end
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
